// File: rtl/dft_pipe_pkg.sv
// Shared definitions for the DFT_compute retiming pipeline.
// DFT_PIPE_SKID_EN: when defined, the pipeline carries a 2-entry skid buffer
// on its output, which widens the occupancy counter.
package dft_pipe_pkg;

  localparam int DFT_WIDTH = 37;

  typedef enum logic {
    MODE_GLOBAL   = 1'b0,
    MODE_COLLAPSE = 1'b1
  } pipe_mode_e;

`ifdef DFT_PIPE_SKID_EN
  localparam bit DFT_PIPE_SKID = 1'b1;
`else
  localparam bit DFT_PIPE_SKID = 1'b0;
`endif

  // Counter must hold 0..DEPTH, or 0..DEPTH+2 once the skid entries exist.
  function automatic int occ_width(input int depth);
    return DFT_PIPE_SKID ? $clog2(depth + 3) : $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/dft_pipe_skid2.sv
// Two-entry skid buffer behind the last pipeline stage. Its ready is a
// register, so the upstream pipeline never sees out_ready combinationally.
module dft_pipe_skid2
  import dft_pipe_pkg::*;
#(
  parameter int WIDTH = DFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic             rdy_q;
  logic             push, pop;

  assign push        = in_valid_i & rdy_q & ~stall_i;
  assign pop         = (cnt_q != 2'd0) & out_ready_i & ~stall_i;
  assign in_ready_o  = rdy_q;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = e0_q;

  // e0 is always the head; a push with a simultaneous pop can only occur at
  // cnt==1 (ready implies cnt<2, pop implies cnt>0), so it lands in e0.
  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = in_data_i;
        else               e1_d = in_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: e0_d = in_data_i;
      default: ;
    endcase
  end

  // Entry storage and the registered ready (free slot after this cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
      rdy_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      rdy_q <= (cnt_d != 2'd2);
    end
  end

endmodule

// File: rtl/dft_compute_retime_pipe.sv
// Stall-aware DEPTH x WIDTH retiming pipeline between the DFT compute kernel
// and the accumulator. COLLAPSE=0 moves all stages together; COLLAPSE=1 lets
// each stage advance on its own so bubbles are squeezed out under backpressure.
// DFT_PIPE_SKID_EN: adds a 2-entry skid buffer on the output (latency +1,
// in_ready no longer depends on out_ready).
module dft_compute_retime_pipe
  import dft_pipe_pkg::*;
#(
  parameter int  WIDTH    = DFT_WIDTH,
  parameter int  DEPTH    = 2,
  parameter int  COLLAPSE = 0,
  localparam int OCC_W    = occ_width(DEPTH)
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             astall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  localparam pipe_mode_e MODE = (COLLAPSE != 0) ? MODE_COLLAPSE : MODE_GLOBAL;

  logic [DEPTH-1:0]            v_q, v_up, ld;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_up;
  logic                        rdy0, sink_ready, accept, emit;
  logic [OCC_W-1:0]            occ_q, occ_d;

  // Source of each stage: stage 0 from the kernel, stage k from stage k-1.
  always_comb begin
    v_up[0] = in_valid;
    d_up[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      v_up[k] = v_q[k-1];
      d_up[k] = d_q[k-1];
    end
  end

  generate
    if (MODE == MODE_COLLAPSE) begin : g_collapse
      logic [DEPTH:0] r;
      // A stage may load when it is empty or its successor is moving.
      always_comb begin
        r        = '0;
        r[DEPTH] = sink_ready;
        for (int k = DEPTH - 1; k >= 0; k--) r[k] = ~v_q[k] | r[k+1];
      end
      assign ld   = {DEPTH{~astall}} & r[DEPTH-1:0];
      assign rdy0 = ~astall & r[0];
    end else begin : g_global
      logic en;
      assign en   = ~astall & (~v_q[DEPTH-1] | sink_ready);
      assign ld   = {DEPTH{en}};
      assign rdy0 = en;
    end
  endgenerate

  // Stage registers; data only captured when a valid entry moves in, so a
  // held entry is never overwritten.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k]) begin
          v_q[k] <= v_up[k];
          if (v_up[k]) d_q[k] <= d_up[k];
        end
      end
    end
  end

`ifdef DFT_PIPE_SKID_EN
  dft_pipe_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk        (aclk),
    .rst_n      (arst_n),
    .stall_i    (astall),
    .in_valid_i (v_q[DEPTH-1]),
    .in_ready_o (sink_ready),
    .in_data_i  (d_q[DEPTH-1]),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data)
  );
`else
  assign sink_ready = out_ready;
  assign out_valid  = v_q[DEPTH-1];
  assign out_data   = d_q[DEPTH-1];
`endif

  // Reset forces in_ready low while the registers are held clear.
  assign in_ready  = rdy0 & arst_n;
  assign accept    = in_valid & rdy0;
  assign emit      = out_valid & out_ready & ~astall;
  assign occupancy = occ_q;

  // Occupancy bookkeeping: +1 accept, -1 emit.
  always_comb begin
    occ_d = occ_q;
    case ({accept, emit})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: ;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) occ_q <= '0;
    else         occ_q <= occ_d;
  end

endmodule

// File: tb/tb_dft_compute_retime_pipe.sv
// Bench for dft_compute_retime_pipe: global-stall and collapsing instances
// driven in parallel, each checked cycle by cycle against a slot-level model
// and an in-order scoreboard.
module tb_dft_compute_retime_pipe;

  localparam int W = 37;
  localparam int D = 2;
`ifdef DFT_PIPE_SKID_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif
  localparam int OW = (SK != 0) ? $clog2(D + 3) : $clog2(D + 2);

  logic         aclk = 1'b0;
  logic         arst_n, astall, in_valid, out_ready;
  logic [W-1:0] in_data;
  wire  [1:0]   ir, ov;
  wire  [W-1:0] od0, od1;
  wire  [OW-1:0] oc0, oc1;

  always #5 aclk = ~aclk;

  dft_compute_retime_pipe #(.WIDTH(W), .DEPTH(D), .COLLAPSE(0)) u_glb (
    .aclk(aclk), .arst_n(arst_n), .astall(astall), .in_valid(in_valid),
    .in_ready(ir[0]), .in_data(in_data), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od0), .occupancy(oc0));

  dft_compute_retime_pipe #(.WIDTH(W), .DEPTH(D), .COLLAPSE(1)) u_col (
    .aclk(aclk), .arst_n(arst_n), .astall(astall), .in_valid(in_valid),
    .in_ready(ir[1]), .in_data(in_data), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od1), .occupancy(oc1));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat_acc, lat_out;

  // model: per mode, DEPTH slots plus optional 2-entry skid queue
  logic         mv[2][D];
  logic [W-1:0] md[2][D];
  logic [W-1:0] sk[2][2];
  int           skc[2];
  int           occ[2];
  logic [W-1:0] sb0[$], sb1[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < D; k++) begin
        mv[m][k] = 1'b0;
        md[m][k] = '0;
      end
      sk[m][0] = '0;
      sk[m][1] = '0;
      skc[m]   = 0;
      occ[m]   = 0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ov"},  64'(ov), 64'd0);
    chk({tag, "_ir"},  64'(ir), 64'd0);
    chk({tag, "_oc0"}, 64'(oc0), 64'd0);
    chk({tag, "_oc1"}, 64'(oc1), 64'd0);
    chk({tag, "_od0"}, 64'(od0), 64'd0);
    chk({tag, "_od1"}, 64'(od1), 64'd0);
  endtask

  // one clock: apply inputs, check both DUTs at negedge, advance model
  task automatic step(input logic iv, input logic [W-1:0] id, input logic st, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    astall    = st;
    out_ready = ordy;
    @(negedge aclk);
    for (int m = 0; m < 2; m++) begin
      logic         r[D+1];
      logic         ld[D];
      logic         srdy, irdy, eov, emit, acc, push, gov;
      logic [W-1:0] eod, god, front;
      int           goc;
      srdy = (SK != 0) ? (skc[m] < 2) : ordy;
      r[D] = srdy;
      for (int k = D - 1; k >= 0; k--) r[k] = !mv[m][k] || r[k+1];
      for (int k = 0; k < D; k++)
        ld[k] = (m == 0) ? (!st && (!mv[m][D-1] || srdy)) : (!st && r[k]);
      irdy = ld[0];
      eov  = (SK != 0) ? (skc[m] > 0) : mv[m][D-1];
      eod  = (SK != 0) ? sk[m][0] : md[m][D-1];
      gov  = ov[m];
      god  = (m == 0) ? od0 : od1;
      goc  = (m == 0) ? int'(oc0) : int'(oc1);
      chk($sformatf("in_ready_m%0d_c%0d", m, cyc), 64'(ir[m]), 64'(irdy));
      chk($sformatf("out_valid_m%0d_c%0d", m, cyc), 64'(gov), 64'(eov));
      chk($sformatf("occupancy_m%0d_c%0d", m, cyc), 64'(goc), 64'(occ[m]));
      if (eov) chk($sformatf("out_data_m%0d_c%0d", m, cyc), 64'(god), 64'(eod));
      emit = eov && ordy && !st;
      acc  = iv && irdy;
      if (emit) begin
        if (m == 0 && sb0.size() > 0) front = sb0.pop_front();
        else if (m == 1 && sb1.size() > 0) front = sb1.pop_front();
        else front = ~god;
        chk($sformatf("order_m%0d_c%0d", m, cyc), 64'(god), 64'(front));
      end
      if (acc) begin
        if (m == 0) sb0.push_back(id);
        else        sb1.push_back(id);
      end
      if (m == 0) begin
        if (acc && lat_acc < 0) lat_acc = cyc;
        if (gov && lat_out < 0 && lat_acc >= 0) lat_out = cyc;
      end
      push = (SK != 0) && mv[m][D-1] && srdy && !st;
      // skid queue: pop head, then append
      if (emit && SK != 0) begin
        sk[m][0] = sk[m][1];
        skc[m]--;
      end
      if (push) begin
        sk[m][skc[m]] = md[m][D-1];
        skc[m]++;
      end
      // stages, downstream first so k-1 still holds its old value
      for (int k = D - 1; k >= 0; k--) begin
        if (ld[k]) begin
          if (k == 0) begin
            mv[m][0] = iv;
            if (iv) md[m][0] = id;
          end else begin
            if (mv[m][k-1]) md[m][k] = md[m][k-1];
            mv[m][k] = mv[m][k-1];
          end
        end
      end
      occ[m] = occ[m] + (acc ? 1 : 0) - (emit ? 1 : 0);
    end
    @(posedge aclk);
    cyc++;
    #1;
  endtask

  initial begin
    logic [W-1:0] base;
    base      = 37'h1_0000_0001;
    arst_n    = 1'b0;
    astall    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    lat_acc   = -1;
    lat_out   = -1;
    model_reset();
    #2;
    chk_reset("por");
    repeat (2) @(posedge aclk);
    #1 arst_n = 1'b1;

    // streaming + latency
    for (int i = 0; i < 5; i++) step(1'b1, base + W'(i), 1'b0, 1'b1);
    repeat (5) step(1'b0, '0, 1'b0, 1'b1);
    chk("latency", 64'(lat_out - lat_acc), 64'(D + SK));

    // stall with the pipe full
    for (int i = 0; i < 2 + 2 * SK; i++) step(1'b1, rnd(), 1'b0, 1'b0);
    repeat (3) step(1'b1, rnd(), 1'b1, 1'b1);
    repeat (6) step(1'b0, '0, 1'b0, 1'b1);

    // backpressure with a bubble behind the first item
    step(1'b1, rnd(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0);
    repeat (6) step(1'b1, rnd(), 1'b0, 1'b1);
    repeat (6) step(1'b0, '0, 1'b0, 1'b1);

    // reset mid-stream, nothing may emerge afterwards
    step(1'b1, rnd(), 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0);
    #2 arst_n = 1'b0;
    #1 chk_reset("midrst");
    model_reset();
    @(posedge aclk);
    #1 arst_n = 1'b1;
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);

    // toggled out_ready over a continuous input stream
    for (int i = 0; i < 40; i++) step(1'b1, rnd(), 1'b0, 1'(i % 2));
    repeat (8) step(1'b0, '0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 2) != 0));
    repeat (8) step(1'b0, '0, 1'b0, 1'b1);
    chk("drain_glb", 64'(sb0.size()), 64'd0);
    chk("drain_col", 64'(sb1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dft_compute_retime_pipe.md
Name: dft_compute_retime_pipe

Overview:
- Parametrised, stall-aware retiming pipeline for DFT_compute datapath results, e.g. the 37-bit float-cos fixed-point output.
- Generalises the fixed 2-stage, stall-only output register into DEPTH stages of WIDTH bits.
- Adds per-stage valid tracking, valid/ready backpressure, selectable global-stall or bubble-collapsing advance, and an occupancy count.
- Sits between a combinational compute kernel and the DFT accumulator.

Parameters:
- WIDTH, 37: data bits per stage.
- DEPTH, 2: pipeline stages, >=1.
- COLLAPSE, 0: 0 = global-stall mode (all stages move together); 1 = bubble-collapsing mode (each stage advances independently).
- OCC_W, $clog2(DEPTH+2): occupancy counter width (derived localparam, not overridable).

Ports:
- aclk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- astall  in  1  global freeze; when 1, no register changes
- in_valid  in  1  upstream data valid
- in_ready  out  1  upstream may transfer this cycle
- in_data  in  WIDTH  kernel result
- out_valid  out  1  stage DEPTH-1 holds data
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  stage DEPTH-1 data
- occupancy  out  OCC_W  valid entries held

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-low (aclk, arst_n).
  - arst_n=0 clears every v[k], every d[k] to 0, and occupancy to 0 immediately.
  - During reset: out_valid=0, out_data=0, in_ready=0.
  - Reset mid-operation discards all in-flight data with no output.
- Stage state: v[k], d[k] for k=0..DEPTH-1. Stage 0 loads from in_data; stage k loads from stage k-1.
- Transfers:
  - Accept when in_valid & in_ready.
  - Emit when out_valid & out_ready.
  - out_data is always d[DEPTH-1]. It is held stable while out_valid & ~out_ready.
- COLLAPSE=0:
  - en = ~astall & (~v[DEPTH-1] | out_ready); in_ready = en.
  - On en, every stage shifts: v[k] <= v[k-1], d[k] <= d[k-1]; v[0] <= in_valid.
  - Bubbles travel intact.
- COLLAPSE=1:
  - r[DEPTH] = out_ready; r[k] = ~v[k] | r[k+1].
  - Stage k loads when ~astall & r[k].
  - v[k] <= (k==0 ? in_valid : v[k-1]).
  - A stage that is emptied and not refilled clears v[k].
  - in_ready = ~astall & r[0].
- in_ready depends combinationally on out_ready and astall (documented comb path) unless the skid option is enabled.
- Data registers load only when their stage enable is asserted. Invalid stages may load garbage, but d of any valid entry is never corrupted.
- Latency: exactly DEPTH cycles from accept to out_valid when unstalled with out_ready=1. Throughput is 1 per cycle.
- occupancy:
  - +1 on accept, -1 on emit, unchanged when both or neither occur.
  - Range 0..DEPTH (DEPTH+2 with skid).
  - Never wraps, by construction, since in_ready=0 when full.
- astall=1 overrides out_ready:
  - No emit and no accept.
  - out_valid/out_data hold.
  - occupancy holds.

Optional Feature:
- DFT_PIPE_SKID_EN defined:
  - Adds a 2-entry skid buffer after stage DEPTH-1.
  - in_ready becomes a registered signal: the pipeline advances only when the skid has at least 1 free entry.
  - Latency is DEPTH+1.
  - Max occupancy is DEPTH+2.
  - No data is lost when out_ready drops with in_ready already high.
- Undefined: no skid buffer; behaviour exactly as above.

Decomposition:
- Shared package dft_pipe_pkg:
  - Default WIDTH constant (37).
  - Mode enum (MODE_GLOBAL=0, MODE_COLLAPSE=1).
  - Occupancy-width function.
- One natural sub-module: dft_pipe_skid2, the 2-entry skid buffer, instantiated only under DFT_PIPE_SKID_EN.

Test Plan (WIDTH=37, DEPTH=2 unless noted):
- Reset: assert arst_n=0 mid-stream with 2 items in flight -> out_valid=0, occupancy=0 asynchronously; no item emerges after release.
- Streaming: 5 back-to-back inputs 0x1_0000_0001..0x1_0000_0005 with out_ready=1 -> outputs appear in order, first out_valid 2 cycles after first accept, one per cycle.
- Stall: astall=1 for 3 cycles with v[0]=v[1]=1 -> out_data is unchanged, in_ready=0, occupancy stays 2; flow resumes with no loss or duplication.
- Backpressure: out_ready=0 for 4 cycles, COLLAPSE=0 versus COLLAPSE=1, with an input bubble at stage 1:
  - COLLAPSE=1 -> stage 1 fills and in_ready stays 1 for one extra accept; occupancy reaches 2.
  - COLLAPSE=0 -> in_ready=0 while out_valid & ~out_ready.
- Simultaneous accept and emit at full occupancy with out_ready=1 -> occupancy unchanged at 2, no data corruption.
- DFT_PIPE_SKID_EN: toggle out_ready every cycle over 20 random inputs -> all 20 outputs in order, latency 3, occupancy never exceeds 4.
